sequnit: RTL and testbench

Multi-cycle instruction sequencer for the accumulator CPU. It fetches 8-bit instructions from the shared program/data memory over a req/ack handshake, holds PC and IR, and fetches operands or stores the accumulator. It then pulses the datapath strobes that write the accumulator and flags. It sits between the memory port and the accumulator/ALU/flag datapath and replaces single-cycle decode with a sequenced FSM.

---
 rtl/sequnit.sv | 187 ++++++++++++++++++
 tb/tb_sequnit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequnit.sv
// Multi-cycle instruction sequencer for the accumulator CPU: fetches over a
// req/ack memory port, fetches operands or stores ACC, then strobes the datapath.
module sequnit #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] acc_i,
  input  logic          z_i,
  input  logic          c_i,
  output logic [DW-1:0] operand_o,
  output logic          acc_we_o,
  output logic          acc_ld_o,
  output logic          alu_sub_o,
  output logic          flag_we_o,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] ir_o,
  output logic          halted_o
);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_MEMWR, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_LDA = 3'b010, OP_STA = 3'b011,
    OP_JMP = 3'b100, OP_JZ  = 3'b101, OP_JC  = 3'b110, OP_HLT = 3'b111
  } op_e;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic acc_we;
    logic acc_ld;
    logic alu_sub;
    logic flag_we;
  } dp_ctl_t;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] operand_q, operand_d;

  mem_req_t      mreq;
  dp_ctl_t       dctl;
  op_e           op;
  logic [AW-1:0] ir_addr;

  assign op      = op_e'(ir_q[DW-1:AW]);
  assign ir_addr = ir_q[AW-1:0];

  // Reset forces START, so req drops immediately without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_START;
      pc_q      <= '0;
      ir_q      <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
    end
  end

  // Ack is only acted on in states that hold req high, so a stray ack elsewhere
  // never moves the machine.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_ADD, OP_SUB, OP_LDA: state_d = S_MEMRD;
          OP_STA:                 state_d = S_MEMWR;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (z_i) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_JC: begin
            if (c_i) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_HALT;
        endcase
      end
      S_MEMRD: begin
        if (mem_ack_i) begin
          operand_d = mem_rdata_i;
          state_d   = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ack_i) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

  // Port and strobe outputs are pure state decode; address/wdata are zero when idle.
  always_comb begin
    mreq     = '0;
    dctl     = '0;
    halted_o = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mreq.req  = 1'b1;
        mreq.addr = pc_q;
      end
      S_MEMRD: begin
        mreq.req  = 1'b1;
        mreq.addr = ir_addr;
      end
      S_MEMWR: begin
        mreq.req   = 1'b1;
        mreq.we    = 1'b1;
        mreq.addr  = ir_addr;
        mreq.wdata = acc_i;
      end
      S_EXEC: begin
        unique case (op)
          OP_ADD: begin
            dctl.acc_we  = 1'b1;
            dctl.flag_we = 1'b1;
          end
          OP_SUB: begin
            dctl.acc_we  = 1'b1;
            dctl.flag_we = 1'b1;
            dctl.alu_sub = 1'b1;
          end
          OP_LDA: begin
            dctl.acc_we = 1'b1;
            dctl.acc_ld = 1'b1;
          end
          default: dctl = '0;
        endcase
      end
      S_HALT:  halted_o = 1'b1;
      default: mreq = '0;
    endcase
  end

  assign mem_req_o   = mreq.req;
  assign mem_we_o    = mreq.we;
  assign mem_addr_o  = mreq.addr;
  assign mem_wdata_o = mreq.wdata;

  assign acc_we_o  = dctl.acc_we;
  assign acc_ld_o  = dctl.acc_ld;
  assign alu_sub_o = dctl.alu_sub;
  assign flag_we_o = dctl.flag_we;

  assign operand_o = operand_q;
  assign pc_o      = pc_q;
  assign ir_o      = ir_q;

endmodule

// File: tb/tb_sequnit.sv
// Bench for sequnit: memory responder with wait states and stray acks, an
// accumulator datapath, and an ISA-level model feeding a scoreboard queue.
module tb_sequnit;
  localparam int AW        = 5;
  localparam int DW        = 8;
  localparam int RUN_LIMIT = 1500;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] acc_i;
  logic          z_i, c_i;
  logic [DW-1:0] operand_o;
  logic          acc_we_o, acc_ld_o, alu_sub_o, flag_we_o;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] ir_o;
  logic          halted_o;

  sequnit #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .acc_i(acc_i), .z_i(z_i), .c_i(c_i),
    .operand_o(operand_o), .acc_we_o(acc_we_o), .acc_ld_o(acc_ld_o),
    .alu_sub_o(alu_sub_o), .flag_we_o(flag_we_o),
    .pc_o(pc_o), .ir_o(ir_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit            strobe;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            ctx;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    bit            ld;
    bit            sub;
    bit            fw;
    logic [DW-1:0] opnd;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endtask

  // Accumulator/flag datapath: 9-bit add/sub, carry = bit 8 (borrow on SUB).
  logic [DW:0] dp_res;
  assign dp_res = alu_sub_o ? ({1'b0, acc_i} - {1'b0, operand_o})
                            : ({1'b0, acc_i} + {1'b0, operand_o});

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_i <= '0;
      z_i   <= 1'b0;
      c_i   <= 1'b0;
    end else begin
      if (acc_we_o) acc_i <= acc_ld_o ? operand_o : dp_res[DW-1:0];
      if (flag_we_o) begin
        z_i <= (dp_res[DW-1:0] == '0);
        c_i <= dp_res[DW];
      end
    end
  end

  // Memory responder: drives ack/rdata just after each rising edge.
  logic [DW-1:0] mem [2**AW];
  int fixed_wait = 0;
  bit spur       = 1'b0;
  bit hold_ack   = 1'b0;
  int wcnt = 0, wtgt = 0, waitsum = 0;

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  always begin
    @(posedge clk_i);
    #1;
    if (hold_ack) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = 8'h55;
    end else if (!rst_ni) begin
      mem_ack_i = 1'b0;
      wcnt      = 0;
      waitsum   = 0;
      wtgt      = pick_wait();
    end else if (mem_req_o) begin
      if (wcnt == wtgt) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem[mem_addr_o];
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        waitsum += wtgt;
        wcnt     = 0;
        wtgt     = pick_wait();
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = DW'($urandom);
        wcnt++;
      end
    end else begin
      mem_ack_i   = spur && ($urandom_range(0, 1) == 1);
      mem_rdata_i = DW'($urandom);
    end
  end

  // ISA-level reference: walks the program over a private copy of memory.
  bit            model_halts = 1'b0;
  int            base_cyc = 0;
  logic [AW-1:0] exp_pc;
  logic [DW-1:0] exp_ir;

  function automatic ev_t mk(bit strobe, bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                             bit ctx, logic [AW-1:0] pc, logic [DW-1:0] ir,
                             bit ld, bit sub, bit fw, logic [DW-1:0] opnd);
    ev_t e;
    e.strobe = strobe; e.we = we; e.addr = addr; e.wdata = wdata;
    e.ctx = ctx; e.pc = pc; e.ir = ir;
    e.ld = ld; e.sub = sub; e.fw = fw; e.opnd = opnd;
    return e;
  endfunction

  task automatic build_model(input int cap);
    logic [DW-1:0] m [2**AW];
    logic [AW-1:0] pc, a;
    logic [DW-1:0] acc, ins, opnd;
    logic [DW:0]   r;
    logic [2:0]    op;
    logic          z, c;
    for (int i = 0; i < 2**AW; i++) m[i] = mem[i];
    pc = '0; acc = '0; z = 1'b0; c = 1'b0;
    model_halts = 1'b0;
    base_cyc    = 0;
    for (int s = 0; s < cap && !model_halts; s++) begin
      ins = m[pc];
      q.push_back(mk(0, 0, pc, '0, 0, '0, '0, 0, 0, 0, '0));
      pc = pc + 1'b1;
      op = ins[DW-1:AW];
      a  = ins[AW-1:0];
      case (op)
        3'd0, 3'd1, 3'd2: begin
          q.push_back(mk(0, 0, a, '0, 1, pc, ins, 0, 0, 0, '0));
          opnd = m[a];
          q.push_back(mk(1, 0, '0, '0, 1, pc, ins, op == 3'd2, op == 3'd1, op != 3'd2, opnd));
          if (op == 3'd2) acc = opnd;
          else begin
            r   = (op == 3'd1) ? ({1'b0, acc} - {1'b0, opnd}) : ({1'b0, acc} + {1'b0, opnd});
            acc = r[DW-1:0];
            c   = r[DW];
            z   = (acc == '0);
          end
          base_cyc += 4;
        end
        3'd3: begin
          q.push_back(mk(0, 1, a, acc, 1, pc, ins, 0, 0, 0, '0));
          m[a] = acc;
          base_cyc += 3;
        end
        3'd4: begin pc = a; base_cyc += 2; end
        3'd5: begin if (z) pc = a; base_cyc += 2; end
        3'd6: begin if (c) pc = a; base_cyc += 2; end
        default: begin
          model_halts = 1'b1;
          base_cyc   += 2;
          exp_pc      = pc;
          exp_ir      = ins;
        end
      endcase
    end
  endtask

  // Monitor: compares every request cycle and strobe against the queue head.
  int cyc = 0;
  int first_req_cyc = -1;
  int halt_cyc = -1;
  bit sb_en = 1'b0;
  logic strb;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      first_req_cyc = -1;
      halt_cyc      = -1;
    end else begin
      if (mem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
      if (halted_o && halt_cyc < 0) halt_cyc = cyc;
      strb = acc_we_o | flag_we_o | acc_ld_o | alu_sub_o;
      if (sb_en && mem_req_o) begin
        if (q.size() == 0) begin
          if (model_halts) check("xfer_extra", mem_req_o, 1'b0);
        end else begin
          mon_e = q[0];
          if (mon_e.strobe) check("xfer_order", mem_req_o, 1'b0);
          else begin
            check("xfer_we", mem_we_o, mon_e.we);
            check("xfer_addr", mem_addr_o, mon_e.addr);
            if (mon_e.we) check("xfer_wdata", mem_wdata_o, mon_e.wdata);
            if (mem_ack_i) begin
              void'(q.pop_front());
              if (mon_e.ctx) begin
                check("xfer_pc", pc_o, mon_e.pc);
                check("xfer_ir", ir_o, mon_e.ir);
              end
            end
          end
        end
      end
      if (sb_en && strb) begin
        if (q.size() == 0) begin
          if (model_halts) check("strobe_extra", strb, 1'b0);
        end else begin
          mon_e = q[0];
          if (!mon_e.strobe) check("strobe_order", strb, 1'b0);
          else begin
            void'(q.pop_front());
            check("acc_we", acc_we_o, 1'b1);
            check("acc_ld", acc_ld_o, mon_e.ld);
            check("alu_sub", alu_sub_o, mon_e.sub);
            check("flag_we", flag_we_o, mon_e.fw);
            check("operand", operand_o, mon_e.opnd);
            check("exec_pc", pc_o, mon_e.pc);
            check("exec_ir", ir_o, mon_e.ir);
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
  endtask

  // Expects rst_ni low on entry; leaves it low on exit.
  task automatic run_prog(input string name, input int cap, input int fw, input bit sp);
    int n;
    fixed_wait = fw;
    spur       = sp;
    q.delete();
    build_model(cap);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    sb_en  = 1'b1;
    n = 0;
    while (n < RUN_LIMIT) begin
      @(negedge clk_i);
      n++;
      if (model_halts ? (halted_o === 1'b1) : (q.size() == 0)) break;
    end
    if (n >= RUN_LIMIT) timeout_fail(name);
    else if (model_halts) begin
      @(negedge clk_i);
      check("halt_cycles", halt_cyc - first_req_cyc, base_cyc + waitsum);
      check("sb_drained", q.size(), 0);
      spur = 1'b1;
      repeat (6) begin
        @(negedge clk_i);
        check("halt_hold", halted_o, 1'b1);
        check("halt_req", mem_req_o, 1'b0);
        check("halt_pc", pc_o, exp_pc);
        check("halt_ir", ir_o, exp_ir);
      end
    end
    sb_en  = 1'b0;
    rst_ni = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with ack held high: everything must stay quiet.
    hold_ack = 1'b1;
    rst_ni   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, '0);
    check("rst_wdata", mem_wdata_o, '0);
    check("rst_acc_we", acc_we_o, 1'b0);
    check("rst_acc_ld", acc_ld_o, 1'b0);
    check("rst_sub", alu_sub_o, 1'b0);
    check("rst_flag_we", flag_we_o, 1'b0);
    check("rst_operand", operand_o, '0);
    check("rst_pc", pc_o, '0);
    check("rst_ir", ir_o, '0);
    check("rst_halted", halted_o, 1'b0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rel_cyc1_req", mem_req_o, 1'b0);
    @(negedge clk_i);
    check("rel_cyc2_req", mem_req_o, 1'b1);
    check("rel_cyc2_addr", mem_addr_o, '0);
    check("rel_cyc2_we", mem_we_o, 1'b0);
    #1 rst_ni = 1'b0;
    hold_ack = 1'b0;

    // LDA 10, ADD 11, STA 12, HLT: zero wait, then three waits per transfer.
    clear_mem();
    mem[0] = 8'h4A; mem[1] = 8'h0B; mem[2] = 8'h6C; mem[3] = 8'hE0;
    mem[10] = 8'd3; mem[11] = 8'd4;
    run_prog("prog_zero_wait", 50, 0, 1'b0);
    check("sta_result", mem[12], 8'd7);

    clear_mem();
    mem[0] = 8'h4A; mem[1] = 8'h0B; mem[2] = 8'h6C; mem[3] = 8'hE0;
    mem[10] = 8'd3; mem[11] = 8'd4;
    run_prog("prog_wait3", 50, 3, 1'b1);
    check("sta_result_wait", mem[12], 8'd7);

    // Branches taken and not taken on Z and C, then JMP 0x1F and PC wrap.
    clear_mem();
    mem[0]  = 8'h54; mem[1]  = 8'h34; mem[2]  = 8'hA5; mem[3]  = 8'hE0;
    mem[4]  = 8'hE0; mem[5]  = 8'hC7; mem[6]  = 8'h15; mem[7]  = 8'hA3;
    mem[8]  = 8'h16; mem[9]  = 8'hCB; mem[10] = 8'hE0; mem[11] = 8'h9F;
    mem[31] = 8'h17;
    mem[20] = 8'd9; mem[21] = 8'hFF; mem[22] = 8'h02; mem[23] = 8'h00;
    run_prog("prog_branch", 16, 0, 1'b0);

    // Reset while MEMRD is waiting for ack.
    clear_mem();
    mem[0] = 8'h0A; mem[10] = 8'h21;
    fixed_wait = 6;
    spur       = 1'b0;
    q.delete();
    build_model(1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    sb_en  = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk_i);
      n++;
      if (mem_req_o && !mem_we_o && mem_addr_o == 5'd10) break;
    end
    if (n >= 100) timeout_fail("memrd_reach");
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_req", mem_req_o, 1'b0);
    check("midrst_operand", operand_o, '0);
    check("midrst_pc", pc_o, '0);
    sb_en = 1'b0;
    q.delete();

    // Random programs (self-modifying code included) with random waits and stray acks.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
      run_prog("prog_random", 40, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    timeout_fail("global_watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
